// File: rtl/ll_pkg.sv
// Shared definitions for the linked-list node store: sizing, pointer type and command opcodes.
package ll_pkg;
    localparam int n     = 16;
    localparam int w_ptr = $clog2(n);

    typedef logic [w_ptr-1:0] ptr_t;

    typedef enum logic [1:0] {
        OP_NEW    = 2'd0,
        OP_APPEND = 2'd1,
        OP_FREE   = 2'd2
    } op_t;
endpackage

// File: rtl/ll_node_table.sv
// next[] pointer table and per-node allocated bits, with a new-node write, a link write
// and combinational lookups for the writer FSM and the external traverser.
module ll_node_table
    import ll_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         new_we,
    input  ptr_t         new_ptr,
    input  logic         link_we,
    input  ptr_t         link_ptr,
    input  ptr_t         link_data,
    input  logic [n-1:0] alloc_clr,
    input  ptr_t         int_rd_ptr,
    output ptr_t         int_rd_next,
    input  ptr_t         head_rd_ptr,
    output ptr_t         head_rd_next,
    input  ptr_t         rd_ptr,
    output ptr_t         rd_next,
    output logic [n-1:0] alloc
);
    ptr_t         next_q [n];
    ptr_t         next_d [n];
    logic [n-1:0] alloc_q;
    logic [n-1:0] alloc_d;

    // Link write is applied last; the writer never targets the same node with both ports.
    always_comb begin
        next_d  = next_q;
        alloc_d = alloc_q & ~alloc_clr;
        if (new_we) begin
            next_d[new_ptr]  = '0;
            alloc_d[new_ptr] = 1'b1;
        end
        if (link_we) begin
            next_d[link_ptr] = link_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < n; i++) begin
                next_q[i] <= (i >= 1 && i < n - 1) ? ptr_t'(i + 1) : '0;
            end
            alloc_q <= '0;
        end else begin
            next_q  <= next_d;
            alloc_q <= alloc_d;
        end
    end

    assign int_rd_next  = next_q[int_rd_ptr];
    assign head_rd_next = next_q[head_rd_ptr];
    assign rd_next      = (rd_ptr == '0) ? '0 : next_q[rd_ptr];
    assign alloc        = alloc_q;
endmodule

// File: rtl/ll_list_writer.sv
// Writer/owner of the node store: allocates nodes for NEW/APPEND and walks a list to
// splice it back onto the free list for FREE.
//   state  | meaning
//   S_IDLE | ready for a command; NEW/APPEND complete in one cycle
//   S_WALK | FREE in progress, one list node inspected per cycle
module ll_list_writer
    import ll_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       cmd_op,
    input  logic [w_ptr-1:0] cmd_ptr,
    input  logic             cmd_vld,
    output logic             cmd_rdy,
    output logic             rsp_vld,
    output logic [w_ptr-1:0] rsp_ptr,
    output logic             rsp_err,
    output logic [w_ptr-1:0] free_cnt,
    input  logic [w_ptr-1:0] rd_ptr,
    output logic [w_ptr-1:0] rd_next
);
    typedef enum logic {S_IDLE, S_WALK} state_t;

    state_t       state_q, state_d;
    ptr_t         free_head_q, free_head_d;
    ptr_t         free_cnt_q, free_cnt_d;
    ptr_t         head_q, head_d;
    ptr_t         cur_q, cur_d;
    ptr_t         len_q, len_d;
    logic [n-1:0] visited_q, visited_d;
    logic         cmd_rdy_q, cmd_rdy_d;
    logic         rsp_vld_q, rsp_vld_d;
    logic         rsp_err_q, rsp_err_d;
    ptr_t         rsp_ptr_q, rsp_ptr_d;

    logic         new_we, link_we, alloc_ok;
    ptr_t         link_ptr, link_data, int_rd_ptr, int_rd_next, head_rd_next;
    logic [n-1:0] alloc_clr, alloc;

    ll_node_table u_table (
        .clk          (clk),
        .rst_n        (rst_n),
        .new_we       (new_we),
        .new_ptr      (free_head_q),
        .link_we      (link_we),
        .link_ptr     (link_ptr),
        .link_data    (link_data),
        .alloc_clr    (alloc_clr),
        .int_rd_ptr   (int_rd_ptr),
        .int_rd_next  (int_rd_next),
        .head_rd_ptr  (free_head_q),
        .head_rd_next (head_rd_next),
        .rd_ptr       (rd_ptr),
        .rd_next      (rd_next),
        .alloc        (alloc)
    );

    always_comb begin
        state_d     = state_q;
        free_head_d = free_head_q;
        free_cnt_d  = free_cnt_q;
        head_d      = head_q;
        cur_d       = cur_q;
        len_d       = len_q;
        visited_d   = visited_q;
        rsp_vld_d   = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_ptr_d   = '0;
        new_we      = 1'b0;
        link_we     = 1'b0;
        link_ptr    = cmd_ptr;
        link_data   = free_head_q;
        alloc_clr   = '0;
        alloc_ok    = 1'b0;
        int_rd_ptr  = (state_q == S_WALK) ? cur_q : cmd_ptr;

        case (state_q)
            S_IDLE: begin
                if (cmd_vld) begin
                    rsp_vld_d = 1'b1;
                    if (cmd_op == OP_NEW || cmd_op == OP_APPEND) begin
                        alloc_ok = (free_cnt_q != '0) &&
                                   (cmd_op == OP_NEW ||
                                    (cmd_ptr != '0 && alloc[cmd_ptr] && int_rd_next == '0));
                        if (alloc_ok) begin
                            new_we      = 1'b1;
                            link_we     = (cmd_op == OP_APPEND);
                            free_head_d = head_rd_next;
                            free_cnt_d  = free_cnt_q - ptr_t'(1);
                            rsp_ptr_d   = free_head_q;
                        end else begin
                            rsp_err_d = 1'b1;
                        end
                    end else if (cmd_op == OP_FREE && cmd_ptr != '0 && alloc[cmd_ptr]) begin
                        rsp_vld_d = 1'b0;
                        head_d    = cmd_ptr;
                        cur_d     = cmd_ptr;
                        visited_d = '0;
                        len_d     = '0;
                        state_d   = S_WALK;
                    end else begin
                        rsp_err_d = 1'b1;
                    end
                end
            end
            S_WALK: begin
                // Nothing is modified until the splice, so an abort leaves the store intact.
                if (!alloc[cur_q] || visited_q[cur_q]) begin
                    rsp_vld_d = 1'b1;
                    rsp_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    visited_d[cur_q] = 1'b1;
                    len_d            = len_q + ptr_t'(1);
                    if (int_rd_next != '0) begin
                        cur_d = int_rd_next;
                    end else begin
                        link_we          = 1'b1;
                        link_ptr         = cur_q;
                        free_head_d      = head_q;
                        alloc_clr        = visited_q;
                        alloc_clr[cur_q] = 1'b1;
                        free_cnt_d       = free_cnt_q + len_q + ptr_t'(1);
                        rsp_vld_d        = 1'b1;
                        rsp_ptr_d        = head_q;
                        state_d          = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        cmd_rdy_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            free_head_q <= ptr_t'(1);
            free_cnt_q  <= ptr_t'(n - 1);
            head_q      <= '0;
            cur_q       <= '0;
            len_q       <= '0;
            visited_q   <= '0;
            cmd_rdy_q   <= 1'b1;
            rsp_vld_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_ptr_q   <= '0;
        end else begin
            state_q     <= state_d;
            free_head_q <= free_head_d;
            free_cnt_q  <= free_cnt_d;
            head_q      <= head_d;
            cur_q       <= cur_d;
            len_q       <= len_d;
            visited_q   <= visited_d;
            cmd_rdy_q   <= cmd_rdy_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_err_q   <= rsp_err_d;
            rsp_ptr_q   <= rsp_ptr_d;
        end
    end

    assign cmd_rdy  = cmd_rdy_q;
    assign rsp_vld  = rsp_vld_q;
    assign rsp_err  = rsp_err_q;
    assign rsp_ptr  = rsp_ptr_q;
    assign free_cnt = free_cnt_q;
endmodule

// File: tb/tb_ll_list_writer.sv
// Bench for ll_list_writer: list-level model (free list as a queue, lists as a next map)
// checked every cycle, plus directed scenarios with literal expectations.
module tb_ll_list_writer;
    import ll_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] cmd_op = '0;
    logic [3:0] cmd_ptr = '0;
    logic       cmd_vld = 1'b0;
    logic       cmd_rdy, rsp_vld, rsp_err;
    logic [3:0] rsp_ptr, free_cnt, rd_next;
    logic [3:0] rd_ptr = '0;

    ll_list_writer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_op   (cmd_op),
        .cmd_ptr  (cmd_ptr),
        .cmd_vld  (cmd_vld),
        .cmd_rdy  (cmd_rdy),
        .rsp_vld  (rsp_vld),
        .rsp_ptr  (rsp_ptr),
        .rsp_err  (rsp_err),
        .free_cnt (free_cnt),
        .rd_ptr   (rd_ptr),
        .rd_next  (rd_next)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Model: free list order kept as a queue; next[] only meaningful for allocated nodes.
    int free_q[$];
    int nxt[16];
    bit alc[16];

    bit chk_en = 1'b0;
    int exp_rdy = 1, exp_vld = 0, exp_err = 0, exp_ptr = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int model_next(input int p);
        if (p == 0) return 0;
        if (alc[p]) return nxt[p];
        foreach (free_q[i]) begin
            if (free_q[i] == p) return (i + 1 < free_q.size()) ? free_q[i + 1] : 0;
        end
        return 0;
    endfunction

    task automatic model_reset();
        free_q.delete();
        for (int i = 1; i < 16; i++) free_q.push_back(i);
        for (int i = 0; i < 16; i++) begin
            nxt[i] = 0;
            alc[i] = 1'b0;
        end
        exp_rdy = 1; exp_vld = 0; exp_err = 0; exp_ptr = 0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_rdy", int'(cmd_rdy), exp_rdy);
            chk("rsp_vld", int'(rsp_vld), exp_vld);
            chk("rsp_err", int'(rsp_err), exp_err);
            chk("rsp_ptr", int'(rsp_ptr), exp_ptr);
            chk("free_cnt", int'(free_cnt), free_q.size());
            chk("rd_next", int'(rd_next), model_next(int'(rd_ptr)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        exp_vld = 0; exp_err = 0; exp_ptr = 0;
        rd_ptr = 4'($urandom_range(0, 15));
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        cmd_vld = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
    endtask

    task automatic peek(input int p, input int exp, input string name);
        rd_ptr = 4'(p);
        #1;
        chk(name, int'(rd_next), exp);
    endtask

    // Drive one command in the current (ready) cycle; return at its response cycle.
    task automatic issue(input int op, input int ptr, output int rptr, output int rerr, output int cyc);
        int  lst[$];
        bit  vis[16];
        int  cur;
        int  node;
        bit  err;
        cmd_op = 2'(op); cmd_ptr = 4'(ptr); cmd_vld = 1'b1;
        err = 1'b0; cyc = 0; rptr = 0;
        foreach (vis[i]) vis[i] = 1'b0;
        case (op)
            0: err = (free_q.size() == 0);
            1: err = (ptr == 0) || !alc[ptr] || (nxt[ptr] != 0) || (free_q.size() == 0);
            2: begin
                if (ptr == 0 || !alc[ptr]) err = 1'b1;
                else begin
                    cur = ptr;
                    for (int k = 0; k < 17; k++) begin
                        if (!alc[cur] || vis[cur]) begin
                            err = 1'b1; cyc = lst.size() + 1; break;
                        end
                        vis[cur] = 1'b1;
                        lst.push_back(cur);
                        if (nxt[cur] == 0) begin
                            cyc = lst.size(); break;
                        end
                        cur = nxt[cur];
                    end
                end
            end
            default: err = 1'b1;
        endcase
        step();
        cmd_vld = 1'b0;
        if (cyc > 0) begin
            exp_rdy = 0;
            repeat (cyc) step();
            exp_rdy = 1;
        end
        exp_vld = 1;
        if (err) begin
            exp_err = 1; exp_ptr = 0;
        end else if (op == 2) begin
            foreach (lst[i]) alc[lst[i]] = 1'b0;
            for (int i = lst.size() - 1; i >= 0; i--) free_q.push_front(lst[i]);
            rptr = ptr;
            exp_ptr = ptr;
        end else begin
            node = free_q.pop_front();
            nxt[node] = 0;
            alc[node] = 1'b1;
            if (op == 1) nxt[ptr] = node;
            rptr = node;
            exp_ptr = node;
        end
        rerr = int'(err);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        int r, e, c, p, sel;
        int cand[$];

        // Reset values and first NEW.
        do_reset();
        chk("rst_cmd_rdy", int'(cmd_rdy), 1);
        chk("rst_rsp_vld", int'(rsp_vld), 0);
        chk("rst_free_cnt", int'(free_cnt), 15);
        issue(0, 0, r, e, c);
        chk("new1_ptr", int'(rsp_ptr), 1);
        chk("new1_err", int'(rsp_err), 0);
        chk("new1_free_cnt", int'(free_cnt), 14);
        peek(1, 0, "new1_rd1");

        // Build 1->2->3, then an illegal append to a non-tail.
        issue(1, 1, r, e, c);
        chk("app2_ptr", r, 2);
        issue(1, 2, r, e, c);
        chk("app3_ptr", int'(rsp_ptr), 3);
        chk("chain_free_cnt", int'(free_cnt), 12);
        peek(1, 2, "chain_rd1");
        peek(2, 3, "chain_rd2");
        peek(3, 0, "chain_rd3");
        issue(1, 1, r, e, c);
        chk("app_bad_err", int'(rsp_err), 1);
        chk("app_bad_ptr", int'(rsp_ptr), 0);
        chk("app_bad_free_cnt", int'(free_cnt), 12);

        // FREE of the 3-node list: 3 walk cycles, response at T+4.
        issue(2, 1, r, e, c);
        chk("free_walk_cycles", c, 3);
        chk("free_rsp_ptr", int'(rsp_ptr), 1);
        chk("free_free_cnt", int'(free_cnt), 15);
        peek(3, 4, "free_rd3");
        issue(0, 0, r, e, c);
        chk("free_then_new", int'(rsp_ptr), 1);

        // Exhaust the free list.
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            issue(0, 0, r, e, c);
            chk("exhaust_ptr", int'(rsp_ptr), i);
        end
        chk("exhaust_free_cnt", int'(free_cnt), 0);
        issue(0, 0, r, e, c);
        chk("exhaust_err", int'(rsp_err), 1);
        chk("exhaust_err_ptr", int'(rsp_ptr), 0);

        // FREE of an unallocated node, of null, and a reserved op.
        do_reset();
        issue(2, 5, r, e, c);
        chk("free5_err", int'(rsp_err), 1);
        peek(15, 0, "free5_rd15");
        chk("free5_free_cnt", int'(free_cnt), 15);
        issue(2, 0, r, e, c);
        chk("free0_err", int'(rsp_err), 1);
        issue(3, 0, r, e, c);
        chk("rsvd_err", int'(rsp_err), 1);

        // Reset in the middle of a 5-node walk.
        do_reset();
        issue(0, 0, r, e, c);
        for (int i = 1; i <= 4; i++) issue(1, i, r, e, c);
        cmd_op = 2'd2; cmd_ptr = 4'd1; cmd_vld = 1'b1;
        step();
        cmd_vld = 1'b0;
        chk_en = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_cmd_rdy", int'(cmd_rdy), 1);
        repeat (3) begin
            @(negedge clk);
            chk("midrst_rsp_vld", int'(rsp_vld), 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        chk("midrst_free_cnt", int'(free_cnt), 15);
        chk("midrst_rdy", int'(cmd_rdy), 1);
        peek(14, 15, "midrst_rd14");
        chk_en = 1'b1;
        step();

        // Randomized traffic against the model.
        for (int it = 0; it < 500; it++) begin
            if ($urandom_range(0, 3) == 0) step();
            sel = $urandom_range(0, 99);
            cand.delete();
            if (sel < 40) begin
                issue(0, 0, r, e, c);
            end else if (sel < 70) begin
                for (int q = 1; q < 16; q++) if (alc[q] && nxt[q] == 0) cand.push_back(q);
                if (cand.size() > 0 && $urandom_range(0, 9) < 8)
                    p = cand[$urandom_range(0, cand.size() - 1)];
                else
                    p = $urandom_range(0, 15);
                issue(1, p, r, e, c);
            end else if (sel < 93) begin
                for (int q = 1; q < 16; q++) if (alc[q]) cand.push_back(q);
                if (cand.size() > 0 && $urandom_range(0, 19) < 17)
                    p = cand[$urandom_range(0, cand.size() - 1)];
                else
                    p = $urandom_range(0, 15);
                issue(2, p, r, e, c);
            end else begin
                issue(3, $urandom_range(0, 15), r, e, c);
            end
        end
        step();
        step();
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
